transceiver_crc_test_sequencer: RTL and testbench
=================================================

// Module: transceiver_crc_test_sequencer
// PURPOSE
// Campaign controller for the CRC error-injection manipulator in the sys_clk_120 domain. Issues N
// single-cycle DLLP/TLP corruption requests with programmable spacing, waits per injection for the
// link replay indication, acknowledges it, and counts recovered vs timed-out injections.
// Sits between the debug control registers and the manipulator's start/ack/replay pins.
// PARAMETERS
// CNT_W  16  width of injection count and result counters
// GAP_W  16  width of inter-injection gap (cycles)
// TO_W   20  width of replay timeout (cycles)
// PORTS
// i_clk           in   1      system clock
// i_rst           in   1      synchronous reset, active-high
// i_start         in   1      pulse: latch cfg, begin campaign (ignored while o_busy)
// i_abort         in   1      pulse: abandon campaign
// i_cfg_mode      in   2      0=DLLP only, 1=TLP only, 2=alternate (DLLP first), 3=reserved (as 0)
// i_cfg_count     in   CNT_W  injections to issue
// i_cfg_gap       in   GAP_W  idle cycles before each injection
// i_cfg_timeout   in   TO_W   max cycles waiting for replay
// i_rply_status   in   1      sticky replay-seen level from manipulator
// o_inject_dllp   out  1      1-cycle DLLP corruption request
// o_inject_tlp    out  1      1-cycle TLP corruption request
// o_rply_ack      out  1      1-cycle clear of i_rply_status
// o_busy          out  1      campaign running
// o_done          out  1      1-cycle pulse at normal completion
// o_aborted       out  1      sticky, set by abort, cleared by next accepted i_start
// o_pass_cnt      out  CNT_W  injections followed by replay
// o_fail_cnt      out  CNT_W  injections that timed out
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; internal counters 0. Reset mid-campaign drops everything.
// - IDLE: i_start -> latch cfg, clear pass/fail/aborted, remaining=i_cfg_count; count==0 -> DONE
//   (o_done next cycle, no injections), else GAP with gap counter=i_cfg_gap. o_busy=1 outside IDLE.
// - GAP: decrement each cycle; at 0 -> INJECT. gap=0 gives INJECT the cycle after entry.
// - INJECT (1 cycle): assert o_inject_dllp or o_inject_tlp per mode (alternate toggles after each
//   injection), load timeout counter, decrement remaining -> WAIT_RPLY.
// - WAIT_RPLY: i_rply_status=1 -> pass_cnt+1, ACK. Timeout counter reaching 0 -> fail_cnt+1, ACK.
//   Both in same cycle -> pass wins. timeout cfg=0 treated as 1.
// - ACK: o_rply_ack=1 each cycle while i_rply_status=1; leave when i_rply_status=0:
//   remaining>0 -> GAP (reload gap), else DONE. Stale replay at entry to WAIT_RPLY counts as pass.
// - DONE (1 cycle): o_done=1, o_busy=0 from next cycle -> IDLE.
// - i_abort in any non-IDLE state has priority over all transitions: -> IDLE, o_aborted=1,
//   no o_done, counters hold values. i_abort in IDLE ignored. i_start+i_abort same cycle in IDLE: start.
// - Counters saturate at all-ones. Never more than one of inject/ack asserted per cycle.
// - Latency: i_start to first inject = i_cfg_gap+2 cycles. All outputs registered.
// STRUCTURE
// - Shared package crc_test_seq_pkg: mode encodings (MODE_DLLP/TLP/ALT), state enum
//   (IDLE, GAP, INJECT, WAIT_RPLY, ACK, DONE).
// - One sub-module: load_down_counter (load, enable, zero flag), instanced for gap and timeout.
// - CDC of controls into sys_clk_120 is handled outside this block.
// TESTING
// - mode=0,count=3,gap=5,timeout=100, replay 10 cycles after each inject -> 3 DLLP pulses, 0 TLP,
//   3 acks, pass=3, fail=0, one o_done; first inject 7 cycles after i_start.
// - mode=2,count=4, replay always -> inject order DLLP,TLP,DLLP,TLP; pass=4.
// - count=2,timeout=8, no replay -> each wait exactly 8 cycles, fail=2, pass=0, o_done pulses.
// - replay asserts on the cycle timeout hits 0 -> pass=1, fail=0; replay held 3 cycles -> 3 acks.
// - abort during WAIT_RPLY of injection 2 -> IDLE next cycle, o_aborted=1, no o_done, pass=1 held;
//   new i_start clears o_aborted and counters.
// - count=0 -> o_done 1 cycle after start, no inject; i_start while busy ignored; i_rst mid-GAP
//   -> all outputs 0 next cycle.

Source files
------------

// File: rtl/crc_test_seq_pkg.sv
// Shared types and encodings for the CRC error-injection campaign sequencer.
package crc_test_seq_pkg;

  // Injection mode encodings; the reserved code behaves like DLLP-only.
  localparam logic [1:0] MODE_DLLP = 2'd0;
  localparam logic [1:0] MODE_TLP  = 2'd1;
  localparam logic [1:0] MODE_ALT  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StGap      = 3'd1,
    StInject   = 3'd2,
    StWaitRply = 3'd3,
    StAck      = 3'd4,
    StDone     = 3'd5
  } state_e;

  // Selects TLP corruption for the next injection; alt_tlp tracks the alternate-mode phase.
  function automatic logic inject_is_tlp(input logic [1:0] mode, input logic alt_tlp);
    logic sel;
    case (mode)
      MODE_TLP: sel = 1'b1;
      MODE_ALT: sel = alt_tlp;
      default:  sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that stops at zero; used for the gap and replay-timeout timers.
module load_down_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] value_q;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_value;
    end else if (en && (value_q != '0)) begin
      value_q <= value_q - WIDTH'(1);
    end
  end

  assign zero = (value_q == '0);

endmodule

// File: rtl/transceiver_crc_test_sequencer.sv
// Campaign controller for the CRC error-injection manipulator: issues spaced DLLP/TLP corruption
// requests, waits for the replay indication, acknowledges it and tallies pass/timeout results.
module transceiver_crc_test_sequencer
  import crc_test_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned GAP_W = 16,
  parameter int unsigned TO_W  = 20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [1:0]       i_cfg_mode,
  input  logic [CNT_W-1:0] i_cfg_count,
  input  logic [GAP_W-1:0] i_cfg_gap,
  input  logic [TO_W-1:0]  i_cfg_timeout,
  input  logic             i_rply_status,
  output logic             o_inject_dllp,
  output logic             o_inject_tlp,
  output logic             o_rply_ack,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic [CNT_W-1:0] o_pass_cnt,
  output logic [CNT_W-1:0] o_fail_cnt
);

  state_e state_q, state_d;

  logic [1:0]       mode_q, mode_d;
  logic [GAP_W-1:0] gap_cfg_q, gap_cfg_d;
  logic [TO_W-1:0]  to_cfg_q, to_cfg_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             alt_tlp_q, alt_tlp_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             aborted_q, aborted_d;

  logic inject_dllp_q, inject_dllp_d;
  logic inject_tlp_q, inject_tlp_d;
  logic ack_q, ack_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic             start_acc;
  logic             abort_acc;
  logic             inject_fire;
  logic             count_pass;
  logic             count_fail;
  logic             tlp_sel;

  logic             gap_load;
  logic             gap_en;
  logic             gap_zero;
  logic [GAP_W-1:0] gap_load_value;
  logic             to_load;
  logic             to_en;
  logic             to_zero;
  logic [TO_W-1:0]  to_load_value;

  assign abort_acc = i_abort && (state_q != StIdle);
  assign tlp_sel   = inject_is_tlp(mode_q, alt_tlp_q);

  // The first gap comes straight from the config inputs; later gaps from the latched copy.
  assign gap_load_value = (state_q == StIdle) ? i_cfg_gap : gap_cfg_q;

  // Counter runs down to zero and times out on the zero cycle, so waiting lasts exactly the
  // configured number of cycles; a zero timeout behaves as one.
  assign to_load_value = (to_cfg_q == '0) ? '0 : to_cfg_q - TO_W'(1);

  load_down_counter #(
    .WIDTH(GAP_W)
  ) u_gap_cnt (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (gap_load),
    .en        (gap_en),
    .load_value(gap_load_value),
    .zero      (gap_zero)
  );

  load_down_counter #(
    .WIDTH(TO_W)
  ) u_to_cnt (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (to_load),
    .en        (to_en),
    .load_value(to_load_value),
    .zero      (to_zero)
  );

  // Next-state logic and timer control; abort overrides every transition outside idle.
  always_comb begin
    state_d     = state_q;
    start_acc   = 1'b0;
    count_pass  = 1'b0;
    count_fail  = 1'b0;
    inject_fire = 1'b0;
    gap_load    = 1'b0;
    gap_en      = 1'b0;
    to_load     = 1'b0;
    to_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          start_acc = 1'b1;
          if (i_cfg_count == '0) begin
            state_d = StDone;
          end else begin
            state_d  = StGap;
            gap_load = 1'b1;
          end
        end
      end
      StGap: begin
        if (gap_zero) begin
          state_d = StInject;
        end else begin
          gap_en = 1'b1;
        end
      end
      StInject: begin
        inject_fire = 1'b1;
        to_load     = 1'b1;
        state_d     = StWaitRply;
      end
      StWaitRply: begin
        // A replay seen on the timeout cycle still counts as recovered.
        if (i_rply_status) begin
          count_pass = 1'b1;
          state_d    = StAck;
        end else if (to_zero) begin
          count_fail = 1'b1;
          state_d    = StAck;
        end else begin
          to_en = 1'b1;
        end
      end
      StAck: begin
        if (!i_rply_status) begin
          if (remaining_q != '0) begin
            state_d  = StGap;
            gap_load = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort_acc) begin
      state_d     = StIdle;
      count_pass  = 1'b0;
      count_fail  = 1'b0;
      inject_fire = 1'b0;
      gap_load    = 1'b0;
      to_load     = 1'b0;
    end
  end

  // Campaign datapath: config latch, remaining count, alternate phase and result counters.
  always_comb begin
    mode_d      = mode_q;
    gap_cfg_d   = gap_cfg_q;
    to_cfg_d    = to_cfg_q;
    remaining_d = remaining_q;
    alt_tlp_d   = alt_tlp_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    aborted_d   = aborted_q;

    if (start_acc) begin
      mode_d      = i_cfg_mode;
      gap_cfg_d   = i_cfg_gap;
      to_cfg_d    = i_cfg_timeout;
      remaining_d = i_cfg_count;
      alt_tlp_d   = 1'b0;
      pass_d      = '0;
      fail_d      = '0;
      aborted_d   = 1'b0;
    end

    if (abort_acc) begin
      aborted_d = 1'b1;
    end

    if (inject_fire) begin
      remaining_d = remaining_q - CNT_W'(1);
      if (mode_q == MODE_ALT) begin
        alt_tlp_d = ~alt_tlp_q;
      end
    end

    if (count_pass && (pass_q != {CNT_W{1'b1}})) begin
      pass_d = pass_q + CNT_W'(1);
    end
    if (count_fail && (fail_q != {CNT_W{1'b1}})) begin
      fail_d = fail_q + CNT_W'(1);
    end
  end

  // Registered outputs are decoded from the upcoming state so they line up with it.
  always_comb begin
    inject_dllp_d = (state_d == StInject) && !tlp_sel;
    inject_tlp_d  = (state_d == StInject) && tlp_sel;
    ack_d         = (state_d == StAck) && i_rply_status;
    busy_d        = (state_d != StIdle);
    done_d        = (state_d == StDone);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      mode_q        <= MODE_DLLP;
      gap_cfg_q     <= '0;
      to_cfg_q      <= '0;
      remaining_q   <= '0;
      alt_tlp_q     <= 1'b0;
      pass_q        <= '0;
      fail_q        <= '0;
      aborted_q     <= 1'b0;
      inject_dllp_q <= 1'b0;
      inject_tlp_q  <= 1'b0;
      ack_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      gap_cfg_q     <= gap_cfg_d;
      to_cfg_q      <= to_cfg_d;
      remaining_q   <= remaining_d;
      alt_tlp_q     <= alt_tlp_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      aborted_q     <= aborted_d;
      inject_dllp_q <= inject_dllp_d;
      inject_tlp_q  <= inject_tlp_d;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign o_inject_dllp = inject_dllp_q;
  assign o_inject_tlp  = inject_tlp_q;
  assign o_rply_ack    = ack_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_aborted     = aborted_q;
  assign o_pass_cnt    = pass_q;
  assign o_fail_cnt    = fail_q;

endmodule

// File: tb/tb_transceiver_crc_test_sequencer.sv
// Scoreboard bench for transceiver_crc_test_sequencer with a simple sticky-replay manipulator model.
module tb_transceiver_crc_test_sequencer;

  localparam int CNT_W = 16;
  localparam int GAP_W = 16;
  localparam int TO_W  = 20;

  localparam int EvDllp = 0;
  localparam int EvTlp  = 1;
  localparam int EvAck  = 2;
  localparam int EvDone = 3;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_start = 1'b0;
  logic             i_abort = 1'b0;
  logic [1:0]       i_cfg_mode = '0;
  logic [CNT_W-1:0] i_cfg_count = '0;
  logic [GAP_W-1:0] i_cfg_gap = '0;
  logic [TO_W-1:0]  i_cfg_timeout = '0;
  logic             i_rply_status = 1'b0;
  logic             o_inject_dllp;
  logic             o_inject_tlp;
  logic             o_rply_ack;
  logic             o_busy;
  logic             o_done;
  logic             o_aborted;
  logic [CNT_W-1:0] o_pass_cnt;
  logic [CNT_W-1:0] o_fail_cnt;

  typedef struct {
    int kind;
    int off;
    int pass;
    int fail;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   base = 0;

  // Manipulator model state
  int   rply_delay = 0;
  int   rply_hold = 1;
  int   rtimer = 0;
  int   rhold = 0;
  logic ack_seen = 1'b0;
  logic kill = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  transceiver_crc_test_sequencer #(
    .CNT_W(CNT_W),
    .GAP_W(GAP_W),
    .TO_W (TO_W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_cfg_mode   (i_cfg_mode),
    .i_cfg_count  (i_cfg_count),
    .i_cfg_gap    (i_cfg_gap),
    .i_cfg_timeout(i_cfg_timeout),
    .i_rply_status(i_rply_status),
    .o_inject_dllp(o_inject_dllp),
    .o_inject_tlp (o_inject_tlp),
    .o_rply_ack   (o_rply_ack),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_aborted    (o_aborted),
    .o_pass_cnt   (o_pass_cnt),
    .o_fail_cnt   (o_fail_cnt)
  );

  function automatic string kname(input int k);
    case (k)
      EvDllp:  return "dllp";
      EvTlp:   return "tlp";
      EvAck:   return "ack";
      default: return "done";
    endcase
  endfunction

  function automatic void exp_push(input int kind, input int off, input int pass, input int fail);
    exp_t e;
    e.kind = kind;
    e.off  = off;
    e.pass = pass;
    e.fail = fail;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  task automatic check_ev(input int kind);
    exp_t e;
    int   off;
    off = cyc - base;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: seen at offset %0d, required no event", kname(kind), off);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.off != off) begin
        bad++;
        $display("FAIL event_order: got %s at offset %0d, required %s at offset %0d",
                 kname(kind), off, kname(e.kind), e.off);
      end else if (kind == EvDone &&
                   (int'(o_pass_cnt) != e.pass || int'(o_fail_cnt) != e.fail)) begin
        bad++;
        $display("FAIL done_counts: got pass=%0d fail=%0d, required pass=%0d fail=%0d",
                 o_pass_cnt, o_fail_cnt, e.pass, e.fail);
      end
    end
  endtask

  // Monitor: every output event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!i_rst) begin
      if (int'(o_inject_dllp) + int'(o_inject_tlp) + int'(o_rply_ack) > 1) begin
        total++;
        bad++;
        $display("FAIL exclusive: inject_dllp=%0b inject_tlp=%0b ack=%0b, required at most one",
                 o_inject_dllp, o_inject_tlp, o_rply_ack);
      end
      if (o_inject_dllp) check_ev(EvDllp);
      if (o_inject_tlp)  check_ev(EvTlp);
      if (o_rply_ack)    check_ev(EvAck);
      if (o_done)        check_ev(EvDone);
    end
  end

  // Manipulator: raise sticky replay rply_delay cycles after an inject, keep it for at least
  // rply_hold cycles and until an ack has been seen.
  always @(negedge clk) begin
    if (kill) begin
      i_rply_status = 1'b0;
      rtimer        = 0;
      rhold         = 0;
      ack_seen      = 1'b0;
    end else begin
      if (i_rply_status) begin
        if (o_rply_ack) ack_seen = 1'b1;
        if (rhold > 0) begin
          rhold--;
        end else if (ack_seen) begin
          i_rply_status = 1'b0;
          ack_seen      = 1'b0;
        end
      end
      if (rtimer > 0) begin
        rtimer--;
        if (rtimer == 0) begin
          i_rply_status = 1'b1;
          rhold         = rply_hold - 1;
          ack_seen      = 1'b0;
        end
      end
      if ((o_inject_dllp || o_inject_tlp) && rply_delay > 0) rtimer = rply_delay;
    end
  end

  task automatic model_reset();
    kill = 1'b1;
    @(negedge clk);
    #1 kill = 1'b0;
  endtask

  // Pulses i_start for one cycle; offsets are measured from the cycle i_start is presented.
  task automatic start_campaign(input int mode, input int count, input int gap, input int to);
    @(negedge clk);
    i_cfg_mode    = 2'(mode);
    i_cfg_count   = CNT_W'(count);
    i_cfg_gap     = GAP_W'(gap);
    i_cfg_timeout = TO_W'(to);
    i_start       = 1'b1;
    base          = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_pending: got %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", int'(o_busy), 0);
    check("rst_inject", int'(o_inject_dllp | o_inject_tlp), 0);
    check("rst_ack_done", int'(o_rply_ack | o_done), 0);
    check("rst_aborted", int'(o_aborted), 0);
    check("rst_pass", int'(o_pass_cnt), 0);
    check("rst_fail", int'(o_fail_cnt), 0);
    i_rst = 1'b0;

    // DLLP only, replay 10 cycles after each inject; a start while busy is ignored
    rply_delay = 10;
    rply_hold  = 1;
    exp_push(EvDllp, 7, 0, 0);
    exp_push(EvAck, 18, 0, 0);
    exp_push(EvDllp, 25, 0, 0);
    exp_push(EvAck, 36, 0, 0);
    exp_push(EvDllp, 43, 0, 0);
    exp_push(EvAck, 54, 0, 0);
    exp_push(EvDone, 55, 3, 0);
    start_campaign(0, 3, 5, 100);
    repeat (19) @(negedge clk);
    check("busy_mid_gap", int'(o_busy), 1);
    i_cfg_count = '0;
    i_cfg_mode  = 2'd1;
    i_start     = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    drain(120, "dllp_only");

    // Alternate mode, prompt replay
    rply_delay = 1;
    exp_push(EvDllp, 2, 0, 0);
    exp_push(EvAck, 4, 0, 0);
    exp_push(EvTlp, 6, 0, 0);
    exp_push(EvAck, 8, 0, 0);
    exp_push(EvDllp, 10, 0, 0);
    exp_push(EvAck, 12, 0, 0);
    exp_push(EvTlp, 14, 0, 0);
    exp_push(EvAck, 16, 0, 0);
    exp_push(EvDone, 17, 4, 0);
    start_campaign(2, 4, 0, 100);
    drain(60, "alternate");

    // TLP only, no replay: every wait times out after 8 cycles
    rply_delay = 0;
    exp_push(EvTlp, 3, 0, 0);
    exp_push(EvTlp, 15, 0, 0);
    exp_push(EvDone, 25, 0, 2);
    start_campaign(1, 2, 1, 8);
    drain(60, "timeout");

    // Replay on the timeout cycle wins; replay held 3 cycles gives 3 acks
    rply_delay = 8;
    rply_hold  = 3;
    exp_push(EvDllp, 2, 0, 0);
    exp_push(EvAck, 11, 0, 0);
    exp_push(EvAck, 12, 0, 0);
    exp_push(EvAck, 13, 0, 0);
    exp_push(EvDone, 14, 1, 0);
    start_campaign(0, 1, 0, 8);
    drain(40, "pass_wins");
    model_reset();

    // Reserved mode acts as DLLP; zero timeout acts as one cycle
    rply_delay = 0;
    rply_hold  = 1;
    exp_push(EvDllp, 2, 0, 0);
    exp_push(EvDone, 5, 0, 1);
    start_campaign(3, 1, 0, 0);
    drain(30, "zero_timeout");

    // Abort while waiting for the second replay
    rply_delay = 3;
    exp_push(EvDllp, 4, 0, 0);
    exp_push(EvAck, 8, 0, 0);
    exp_push(EvDllp, 12, 0, 0);
    start_campaign(0, 3, 2, 50);
    repeat (13) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_busy", int'(o_busy), 0);
    check("abort_flag", int'(o_aborted), 1);
    check("abort_pass_held", int'(o_pass_cnt), 1);
    check("abort_fail_held", int'(o_fail_cnt), 0);
    model_reset();
    rply_delay = 0;
    repeat (10) @(negedge clk);
    check("abort_flag_sticky", int'(o_aborted), 1);
    drain(2, "abort");

    // Zero-count campaign: immediate done, clears aborted and counters
    exp_push(EvDone, 1, 0, 0);
    start_campaign(0, 0, 0, 0);
    check("restart_aborted", int'(o_aborted), 0);
    drain(10, "zero_count");

    // Synchronous reset in the middle of a gap
    start_campaign(2, 1, 10, 100);
    repeat (4) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_outputs", int'(o_inject_dllp | o_inject_tlp | o_rply_ack | o_done), 0);
    check("midrst_counts", int'(o_pass_cnt | o_fail_cnt), 0);
    repeat (20) @(negedge clk);
    check("midrst_idle", int'(o_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
